// File: rtl/ode_step_sequencer_if.sv
// Handshake and counter bus between the ODE step sequencer, the solver
// datapath and the downstream negedge step down-counter.
interface ode_step_sequencer_if #(
    parameter int WORD_SIZE = 32
);
    logic                 start;
    logic                 abort;
    logic [WORD_SIZE-1:0] num_steps;
    logic                 step_done;
    logic [WORD_SIZE-1:0] cnt_count;
    logic                 cnt_load;
    logic [WORD_SIZE-1:0] cnt_load_data;
    logic                 cnt_enable;
    logic                 step_req;
    logic [WORD_SIZE-1:0] step_idx;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        input  start, abort, num_steps, step_done, cnt_count,
        output cnt_load, cnt_load_data, cnt_enable, step_req, step_idx,
               busy, done, error
    );

    modport slave (
        output start, abort, num_steps, step_done, cnt_count,
        input  cnt_load, cnt_load_data, cnt_enable, step_req, step_idx,
               busy, done, error
    );
endinterface

// File: rtl/ode_step_sequencer.sv
// Control FSM that runs a fixed number of ODE integration steps through an
// external negedge down-counter, with per-step watchdog, abort and completion.
module ode_step_sequencer #(
    parameter int WORD_SIZE = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    ode_step_sequencer_if.master bus
);
    localparam int WD_W = $clog2(TIMEOUT + 2);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHECK, S_REQ, S_ADVANCE, S_DONE, S_ERROR
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [WORD_SIZE-1:0] r_n;
    logic [WD_W-1:0]      r_wd;
    logic                 w_latch;
    logic                 w_active;
    logic                 w_wd_expired;
    logic                 w_load;
    logic                 w_enable;
    logic                 w_req;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_error;

    // Abort only applies to the states that touch the counter or the solver
    assign w_active     = r_state inside {S_LOAD, S_CHECK, S_REQ, S_ADVANCE};
    assign w_wd_expired = (TIMEOUT != 0) && (r_wd == WD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_wd    <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_n <= bus.num_steps;
            end
            r_wd <= (r_state == S_REQ && w_next == S_REQ) ? r_wd + 1'b1 : '0;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        w_load   = 1'b0;
        w_enable = 1'b0;
        w_req    = 1'b0;
        w_busy   = 1'b1;
        w_done   = 1'b0;
        w_error  = 1'b0;
        case (r_state)
            S_IDLE, S_ERROR: begin
                w_busy  = 1'b0;
                w_error = (r_state == S_ERROR);
                if (bus.start) begin
                    if (bus.num_steps != '0) begin
                        w_latch = 1'b1;
                        w_next  = S_LOAD;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                w_load = !bus.abort;
                w_next = S_CHECK;
            end
            S_CHECK: w_next = (bus.cnt_count == '0) ? S_DONE : S_REQ;
            S_REQ: begin
                w_req = 1'b1;
                // A step_done arriving on the expiry cycle still counts as success
                if (bus.step_done) begin
                    w_next = S_ADVANCE;
                end else if (w_wd_expired) begin
                    w_next = S_ERROR;
                end
            end
            S_ADVANCE: begin
                w_enable = !bus.abort;
                w_next   = S_CHECK;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (bus.abort && w_active) begin
            w_next = S_IDLE;
        end
    end

    assign bus.cnt_load      = w_load;
    assign bus.cnt_enable    = w_enable;
    assign bus.cnt_load_data = r_n;
    assign bus.step_req      = w_req;
    assign bus.busy          = w_busy;
    assign bus.done          = w_done;
    assign bus.error         = w_error;
    assign bus.step_idx      = w_busy ? r_n - bus.cnt_count : '0;
endmodule

// File: tb/tb_ode_step_sequencer.sv
// Bench for ode_step_sequencer: models the negedge down-counter and checks each
// cycle against the run timeline implied by the step-sequencing rules.
module tb_ode_step_sequencer;
    localparam int W  = 32;
    localparam int TO = 8;

    localparam logic [5:0] IDLE = 6'b000000;
    localparam logic [5:0] ERR  = 6'b000001;
    localparam logic [5:0] LOAD = 6'b100100;
    localparam logic [5:0] CHK  = 6'b000100;
    localparam logic [5:0] REQ  = 6'b001100;
    localparam logic [5:0] ADV  = 6'b010100;
    localparam logic [5:0] DONE = 6'b000110;

    logic         clk;
    logic         rst;
    logic [W-1:0] cnt;
    int           n_vec;
    int           n_bad;
    bit           m_err;

    ode_step_sequencer_if #(.WORD_SIZE(W)) bus ();

    ode_step_sequencer #(.WORD_SIZE(W), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream step counter: IS_DOWN, captures strobes on the falling edge
    always @(negedge clk or posedge rst) begin
        if (rst)                cnt <= '0;
        else if (bus.cnt_load)  cnt <= bus.cnt_load_data;
        else if (bus.cnt_enable) cnt <= cnt - 1'b1;
    end
    assign bus.cnt_count = cnt;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not reach its end, required completion");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] ctl();
        return {bus.cnt_load, bus.cnt_enable, bus.step_req, bus.busy, bus.done, bus.error};
    endfunction

    // Called at +1 after a rising edge with this cycle's inputs applied.
    task automatic cyc(input logic [5:0] e, input bit ci, input logic [W-1:0] ei);
        #6;
        check_eq("ctl{load,en,req,busy,done,err}", {58'd0, ctl()}, {58'd0, e});
        if (ci) check_eq("step_idx", {32'd0, bus.step_idx}, {32'd0, ei});
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.step_done = 1'b0;
        bus.num_steps = $urandom;
    endtask

    task automatic busy_noise();
        bus.start     = 1'($urandom_range(0, 1));
        bus.step_done = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_cyc(input bit noise);
        if (noise) begin
            bus.step_done = 1'($urandom_range(0, 1));
            bus.abort     = 1'($urandom_range(0, 1));
        end
        cyc(IDLE, 1'b1, '0);
    endtask

    function automatic int pick_dly();
        int r;
        r = int'($urandom_range(0, 4));
        return (r == 3) ? TO - 1 : (r == 4) ? 0 : r;
    endfunction

    // One run: dly<0 picks random per-step solver latency; ab_ph 0..3 selects
    // LOAD/CHECK/REQ(with step_done)/ADVANCE of step ab_step; wh_step withholds step_done.
    task automatic run(input logic [W-1:0] n, input int dly, input int ab_step,
                       input int ab_ph, input int wh_step, input bit noise);
        int d;
        bit ab;
        bus.start     = 1'b1;
        bus.num_steps = n;
        if (noise) bus.abort = 1'($urandom_range(0, 1));
        cyc(m_err ? ERR : IDLE, 1'b1, '0);
        m_err = 1'b0;
        if (n == '0) begin
            cyc(DONE, 1'b0, '0);
            idle_cyc(noise);
            return;
        end
        if (noise) busy_noise();
        ab = (ab_step == 0 && ab_ph == 0);
        bus.abort = ab;
        check_eq("cnt_load_data", {32'd0, bus.cnt_load_data}, {32'd0, n});
        cyc(ab ? CHK : LOAD, 1'b0, '0);
        if (ab) begin
            idle_cyc(noise);
            return;
        end
        for (int i = 0; i < 64; i++) begin
            if (noise) busy_noise();
            ab = (ab_step == i && ab_ph == 1);
            bus.abort = ab;
            check_eq("cnt_count", {32'd0, bus.cnt_count}, {32'd0, n - W'(i)});
            cyc(CHK, 1'b1, W'(i));
            if (ab) begin
                idle_cyc(noise);
                return;
            end
            if (W'(i) == n) begin
                if (noise) begin
                    busy_noise();
                    bus.abort = 1'($urandom_range(0, 1));
                end
                cyc(DONE, 1'b1, n);
                idle_cyc(noise);
                return;
            end
            d = (dly < 0) ? pick_dly() : dly;
            if (wh_step == i) d = TO;
            for (int j = 0; j <= d && j < TO; j++) begin
                bus.step_done = (j == d);
                ab = (ab_step == i && ab_ph == 2 && j == d);
                bus.abort = ab;
                cyc(REQ, 1'b1, W'(i));
                if (ab) begin
                    idle_cyc(noise);
                    return;
                end
            end
            if (d >= TO) begin
                m_err = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    if (noise) begin
                        bus.abort     = 1'($urandom_range(0, 1));
                        bus.step_done = 1'($urandom_range(0, 1));
                    end
                    cyc(ERR, 1'b1, '0);
                end
                return;
            end
            if (noise) busy_noise();
            ab = (ab_step == i && ab_ph == 3);
            bus.abort = ab;
            cyc(ab ? CHK : ADV, 1'b1, ab ? W'(i) : W'(i + 1));
            if (ab) begin
                idle_cyc(noise);
                return;
            end
        end
    endtask

    initial begin
        n_vec         = 0;
        n_bad         = 0;
        m_err         = 1'b0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.step_done = 1'b0;
        bus.num_steps = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ctl", {58'd0, ctl()}, 64'd0);
        check_eq("rst_step_idx", {32'd0, bus.step_idx}, 64'd0);
        check_eq("rst_load_data", {32'd0, bus.cnt_load_data}, 64'd0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        run(32'd3, 2, -1, 0, -1, 1'b0);
        run(32'd0, 0, -1, 0, -1, 1'b0);
        run(32'd2, 1, -1, 0, 0, 1'b0);
        run(32'd1, 0, -1, 0, -1, 1'b0);
        run(32'd4, 1, 1, 2, -1, 1'b0);
        run(32'd3, -1, -1, 0, -1, 1'b1);
        run(32'hFFFF_FFFF, 0, 2, 1, -1, 1'b0);
        run(32'd2, TO - 1, -1, 0, -1, 1'b0);

        // Asynchronous reset in the middle of a request
        bus.start     = 1'b1;
        bus.num_steps = 32'd3;
        cyc(IDLE, 1'b1, '0);
        cyc(LOAD, 1'b0, '0);
        cyc(CHK, 1'b1, '0);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_ctl", {58'd0, ctl()}, 64'd0);
        check_eq("arst_step_idx", {32'd0, bus.step_idx}, 64'd0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        run(32'd2, 0, -1, 0, -1, 1'b0);

        for (int r = 0; r < 25; r++) begin
            logic [W-1:0] n;
            int ab_step, ab_ph, wh;
            n       = W'($urandom_range(0, 5));
            ab_step = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
            ab_ph   = int'($urandom_range(0, 3));
            wh      = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
            run(n, -1, ab_step, ab_ph, wh, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
